// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0/E1 prefixes into one key event, tracks modifiers, drops status bytes.
// Optional typematic repeat filter enabled by defining PS2DEC_REPEAT_FILTER_EN.
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000,
  parameter int unsigned TO_W           = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       err_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_PFX, S_PAUSE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state, w_state_nxt;
  logic            r_e0, r_f0, w_e0_nxt, w_f0_nxt;
  logic [2:0]      r_skip, w_skip_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_key_code;
  logic            r_key_release, r_key_extended, r_key_valid;
  logic            r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
  logic            r_err;
  logic            w_accept, w_timeout, w_err_set, w_raw_evt, w_pause_evt;
  logic            w_swallow, w_load, w_ld_rel, w_ld_ext;
  logic [7:0]      w_ld_code;

  assign sym_ready = ~r_key_valid | key_ready;
  assign w_accept  = sym_valid & sym_ready;
  assign w_timeout = (r_state != S_IDLE) & ~w_accept & (r_to_cnt == TO_LAST);

  // State register and sequence timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_e0     <= 1'b0;
      r_f0     <= 1'b0;
      r_skip   <= '0;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_e0    <= w_e0_nxt;
      r_f0    <= w_f0_nxt;
      r_skip  <= w_skip_nxt;
      if (w_accept || (w_state_nxt == S_IDLE))
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_e0_nxt    = r_e0;
    w_f0_nxt    = r_f0;
    w_skip_nxt  = r_skip;
    w_err_set   = 1'b0;
    w_raw_evt   = 1'b0;
    w_pause_evt = 1'b0;
    if (w_accept) begin
      if (r_state == S_PAUSE) begin
        if (r_skip == 3'd1) begin
          w_pause_evt = 1'b1;
          w_skip_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_skip_nxt = r_skip - 3'd1;
        end
      end else if (sym_data == 8'hE0) begin
        w_e0_nxt    = 1'b1;
        w_state_nxt = S_PFX;
      end else if (sym_data == 8'hF0) begin
        w_f0_nxt    = 1'b1;
        w_state_nxt = S_PFX;
      end else if (sym_data == 8'hE1) begin
        w_e0_nxt    = 1'b0;
        w_f0_nxt    = 1'b0;
        w_skip_nxt  = 3'd7;
        w_state_nxt = S_PAUSE;
      end else if ((sym_data == 8'h00) || (sym_data == 8'hFF)) begin
        w_err_set   = 1'b1;
        w_e0_nxt    = 1'b0;
        w_f0_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end else if ((sym_data == 8'hAA) && (r_state == S_IDLE)) begin
        w_state_nxt = S_IDLE;
      end else if ((sym_data == 8'hFA) || (sym_data == 8'hFE) || (sym_data == 8'hEE)) begin
        w_state_nxt = r_state;
      end else begin
        w_raw_evt   = 1'b1;
        w_e0_nxt    = 1'b0;
        w_f0_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end else if (w_timeout) begin
      w_e0_nxt    = 1'b0;
      w_f0_nxt    = 1'b0;
      w_skip_nxt  = '0;
      w_state_nxt = S_IDLE;
    end
  end

`ifdef PS2DEC_REPEAT_FILTER_EN
  logic [7:0] r_last_code;
  logic       r_last_ext, r_last_vld;

  // Pause events bypass the filter; only ordinary make/break bytes touch last_make.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_code <= '0;
      r_last_ext  <= 1'b0;
      r_last_vld  <= 1'b0;
    end else if (w_raw_evt) begin
      if (r_f0) begin
        if ((sym_data == r_last_code) && (r_e0 == r_last_ext))
          r_last_vld <= 1'b0;
      end else begin
        r_last_code <= sym_data;
        r_last_ext  <= r_e0;
        r_last_vld  <= 1'b1;
      end
    end
  end

  assign w_swallow = w_raw_evt & ~r_f0 & r_last_vld &
                     (sym_data == r_last_code) & (r_e0 == r_last_ext);
`else
  assign w_swallow = 1'b0;
`endif

  // Event outputs to be loaded this edge
  always_comb begin
    w_load    = (w_raw_evt & ~w_swallow) | w_pause_evt;
    w_ld_code = w_pause_evt ? 8'hE1 : sym_data;
    w_ld_rel  = w_raw_evt & r_f0;
    w_ld_ext  = w_raw_evt & r_e0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid    <= 1'b0;
      r_key_code     <= '0;
      r_key_release  <= 1'b0;
      r_key_extended <= 1'b0;
    end else if (w_load) begin
      r_key_valid    <= 1'b1;
      r_key_code     <= w_ld_code;
      r_key_release  <= w_ld_rel;
      r_key_extended <= w_ld_ext;
    end else if (key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
      r_lalt   <= 1'b0;
      r_ralt   <= 1'b0;
    end else if (w_raw_evt && !w_swallow) begin
      case ({r_e0, sym_data})
        9'h012:  r_lshift <= ~r_f0;
        9'h059:  r_rshift <= ~r_f0;
        9'h014:  r_lctrl  <= ~r_f0;
        9'h114:  r_rctrl  <= ~r_f0;
        9'h011:  r_lalt   <= ~r_f0;
        9'h111:  r_ralt   <= ~r_f0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_err_set)
      r_err <= 1'b1;
  end

  assign key_valid    = r_key_valid;
  assign key_code     = r_key_code;
  assign key_release  = r_key_release;
  assign key_extended = r_key_extended;
  assign mod_shift    = r_lshift | r_rshift;
  assign mod_ctrl     = r_lctrl | r_rctrl;
  assign mod_alt      = r_lalt | r_ralt;
  assign err_overrun  = r_err;

endmodule
